// File: rtl/reg_scoreboard.sv
// reg_scoreboard: GPR hazard scoreboard for an in-order pipeline.
// Tracks one in-flight writer per GPR as a busy bit plus a 2-bit countdown
// to forwardability. It flags ID-stage stalls when a source operand is
// needed before its producer can forward it.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   issue_valid/waddr/tnew         instruction issuing into EX (waddr 0 = no write)
//   rs_addr/rt_addr, rs/rt_tuse    ID-stage sources and cycles until use (3 = unused)
//   wb_valid/wb_waddr              write-back retiring a GPR write
//   flush                          discard all in-flight writers
//   stall, rs_busy, rt_busy        combinational hazard indications
//   pending                        registered count of busy entries
module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] issue_waddr,
  input  logic [1:0] issue_tnew,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic [1:0] rs_tuse,
  input  logic [1:0] rt_tuse,
  input  logic       wb_valid,
  input  logic [4:0] wb_waddr,
  input  logic       flush,
  output logic       stall,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic [5:0] pending
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 2;
  localparam int unsigned PW    = 6;

  logic [NREG-1:0]         busy_q, busy_d;
  logic [NREG-1:0][CW-1:0] cnt_q,  cnt_d;
  logic [PW-1:0]           pending_q, pending_d;
  logic                    issue_accept;

  // Hazard view reflects registered state only; same-cycle write-back does not unstall.
  always_comb begin
    rs_busy = busy_q[rs_addr] && (rs_addr != '0);
    rt_busy = busy_q[rt_addr] && (rt_addr != '0);
    // cnt never exceeds 3, so a tuse of 3 can never stall.
    stall   = (rs_busy && (cnt_q[rs_addr] > rs_tuse)) ||
              (rt_busy && (cnt_q[rt_addr] > rt_tuse));
  end

  assign issue_accept = issue_valid && !stall && !flush;

  // Next-state per entry: flush > issue > write-back > countdown.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pending_d = '0;
    for (int i = 1; i < NREG; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (issue_accept && (issue_waddr == AW'(i))) begin
        busy_d[i] = 1'b1;
        cnt_d[i]  = issue_tnew;
      end else if (wb_valid && (wb_waddr == AW'(i))) begin
        busy_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (busy_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i]  = cnt_q[i] - CW'(1);
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
    for (int i = 1; i < NREG; i++) begin
      pending_d = pending_d + PW'(busy_d[i]);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule
